// File: rtl/elevator_pkg.sv
// Shared types and constants for the elevator call scheduler.
//   FLOOR_W / TOP_FLOOR : floor encoding ({z1,z0}, 0 = ground, 3 = top)
//   CMD_*               : move command encoding on {x1,x0}
//   state_e             : scheduler FSM states
package elevator_pkg;

  localparam int unsigned FLOOR_W = 2;
  localparam logic [FLOOR_W-1:0] TOP_FLOOR = 2'd3;

  localparam logic [1:0] CMD_UP   = 2'b11;
  localparam logic [1:0] CMD_DOWN = 2'b01;
  localparam logic [1:0] CMD_HOLD = 2'b00;

  typedef enum logic [2:0] {
    StIdle,
    StMove,
    StWaitArrive,
    StDwell,
    StHalt
  } state_e;

endpackage

// File: rtl/elevator_call_latch.sv
// Outstanding-call register for the elevator scheduler.
//   clk, rst_n  : clock, asynchronous active-low reset
//   call_i      : call buttons, OR-ed into the pending set every cycle
//   clear_i     : one-hot floor being served; wins over a same-cycle call
//   flush_i     : drop every pending call (fire recall)
//   pending_o   : latched outstanding calls
//   served_o    : one-cycle one-hot pulse for the floor just cleared
module elevator_call_latch #(
  parameter int unsigned NumFloors = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NumFloors-1:0] call_i,
  input  logic [NumFloors-1:0] clear_i,
  input  logic                 flush_i,
  output logic [NumFloors-1:0] pending_o,
  output logic [NumFloors-1:0] served_o
);

  logic [NumFloors-1:0] pending_q, pending_d;
  logic [NumFloors-1:0] served_q;

  always_comb begin
    pending_d = (pending_q | call_i) & ~clear_i;
    if (flush_i) pending_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      served_q  <= '0;
    end else begin
      pending_q <= pending_d;
      // Only report floors that were actually outstanding.
      served_q  <= clear_i & pending_q;
    end
  end

  assign pending_o = pending_q;
  assign served_o  = served_q;

endmodule

// File: rtl/elevator_call_scheduler.sv
// SCAN call scheduler feeding the elevator car controller.
//   clk, rst_n   : clock, asynchronous active-low reset
//   call_i       : call buttons (one bit per floor)
//   emergency    : emergency stop
//   floor_i      : current car floor {z1,z0}
//   x1, x0       : move command (11 up, 01 down, 00 hold)
//   pending_o    : latched outstanding calls
//   served_o     : one-cycle pulse when a floor's call is cleared
//   dir_up_o     : sweep direction (1 = up)
//   door_open_o  : high while dwelling at a served floor
//   fault_o      : sticky arrival-timeout flag
// Build option: FIRE_RECALL_EN turns emergency into a recall to floor 0
// instead of a freeze.
module elevator_call_scheduler
  import elevator_pkg::*;
#(
  parameter int unsigned NUM_FLOORS     = 4,
  parameter int unsigned DWELL_CYCLES   = 4,
  parameter int unsigned ARRIVE_TIMEOUT = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_FLOORS-1:0] call_i,
  input  logic                  emergency,
  input  logic [FLOOR_W-1:0]    floor_i,
  output logic                  x1,
  output logic                  x0,
  output logic [NUM_FLOORS-1:0] pending_o,
  output logic [NUM_FLOORS-1:0] served_o,
  output logic                  dir_up_o,
  output logic                  door_open_o,
  output logic                  fault_o
);

  localparam logic [3:0] DwellLast   = 4'(DWELL_CYCLES - 1);
  localparam logic [3:0] TimeoutLast = 4'(ARRIVE_TIMEOUT - 1);

  state_e               state_q, state_d;
  logic [1:0]           cmd_q, cmd_d;
  logic                 dir_up_q, dir_up_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [FLOOR_W-1:0]   floor_q, floor_d;
  logic                 fault_q, fault_d;
  logic                 recall_done_q, recall_done_d;
  logic [NUM_FLOORS-1:0] clear;
  logic                 calls_above, calls_below;
  logic                 go_up, go_down;
  logic                 freeze, recall;

`ifdef FIRE_RECALL_EN
  assign recall = emergency;
  assign freeze = 1'b0;
`else
  assign recall = 1'b0;
  assign freeze = emergency;
`endif

  elevator_call_latch #(
    .NumFloors (NUM_FLOORS)
  ) u_call_latch (
    .clk       (clk),
    .rst_n     (rst_n),
    .call_i    (call_i),
    .clear_i   (clear),
    .flush_i   (recall),
    .pending_o (pending_o),
    .served_o  (served_o)
  );

  always_comb begin
    calls_above = 1'b0;
    calls_below = 1'b0;
    for (int unsigned f = 0; f < NUM_FLOORS; f++) begin
      if (pending_o[f] && (f > 32'(floor_i))) calls_above = 1'b1;
      if (pending_o[f] && (f < 32'(floor_i))) calls_below = 1'b1;
    end
  end

  // SCAN: keep the sweep while calls remain ahead, otherwise turn around.
  assign go_up   = calls_above && (dir_up_q || !calls_below);
  assign go_down = calls_below && (!dir_up_q || !calls_above);

  always_comb begin
    state_d       = state_q;
    cmd_d         = cmd_q;
    dir_up_d      = dir_up_q;
    cnt_d         = cnt_q;
    floor_d       = floor_q;
    fault_d       = fault_q;
    recall_done_d = recall_done_q & recall;
    clear         = '0;
    if (freeze) begin
      // Frozen; the arrival timer restarts once the stop is released.
      if (state_q == StWaitArrive) cnt_d = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (recall) begin
            if (floor_i != '0) begin
              cmd_d   = CMD_DOWN;
              state_d = StMove;
            end else if (!recall_done_q) begin
              recall_done_d = 1'b1;
              cnt_d         = '0;
              state_d       = StDwell;
            end
          end else begin
            if (floor_i == TOP_FLOOR) dir_up_d = 1'b0;
            else if (floor_i == '0)   dir_up_d = 1'b1;
            if (pending_o[floor_i]) begin
              clear[floor_i] = 1'b1;
              cnt_d          = '0;
              state_d        = StDwell;
            end else if (go_up) begin
              dir_up_d = 1'b1;
              cmd_d    = CMD_UP;
              state_d  = StMove;
            end else if (go_down) begin
              dir_up_d = 1'b0;
              cmd_d    = CMD_DOWN;
              state_d  = StMove;
            end
          end
        end
        StMove: begin
          floor_d = floor_i;
          cmd_d   = CMD_HOLD;
          cnt_d   = '0;
          state_d = StWaitArrive;
        end
        StWaitArrive: begin
          if (floor_i != floor_q) begin
            state_d = StIdle;
          end else if (cnt_q == TimeoutLast) begin
            fault_d = 1'b1;
            state_d = StHalt;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        StDwell: begin
          if (cnt_q == DwellLast) state_d = StIdle;
          else                    cnt_d   = cnt_q + 4'd1;
        end
        StHalt: ;
        default: state_d = StIdle;
      endcase
      if (recall) dir_up_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      cmd_q         <= CMD_HOLD;
      dir_up_q      <= 1'b1;
      cnt_q         <= '0;
      floor_q       <= '0;
      fault_q       <= 1'b0;
      recall_done_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cmd_q         <= cmd_d;
      dir_up_q      <= dir_up_d;
      cnt_q         <= cnt_d;
      floor_q       <= floor_d;
      fault_q       <= fault_d;
      recall_done_q <= recall_done_d;
    end
  end

  // Emergency masking is the only combinational path to the command.
  assign {x1, x0}    = freeze ? CMD_HOLD : cmd_q;
  assign dir_up_o    = dir_up_q;
  assign door_open_o = (state_q == StDwell);
  assign fault_o     = fault_q;

endmodule

// File: tb/tb_elevator_call_scheduler.sv
// Scoreboard bench for elevator_call_scheduler. Expected output events
// (commands, served pulses, fault rise) are queued by the stimulus and
// popped by an independent monitor; a small car model advances floor_i.
module tb_elevator_call_scheduler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] call_i = '0;
  logic       emergency = 1'b0;
  logic [1:0] floor_i = '0;
  logic       x1, x0;
  logic [3:0] pending_o, served_o;
  logic       dir_up_o, door_open_o, fault_o;

  int         n_checks = 0;
  int         n_fail = 0;
  logic [7:0] exp_q[$];   // {kind, value}: 1x = command, 2x = served, 30 = fault
  logic       car_en = 1'b0;
  logic       prev_fault = 1'b0;

  elevator_call_scheduler #(
    .NUM_FLOORS     (4),
    .DWELL_CYCLES   (4),
    .ARRIVE_TIMEOUT (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .call_i      (call_i),
    .emergency   (emergency),
    .floor_i     (floor_i),
    .x1          (x1),
    .x0          (x0),
    .pending_o   (pending_o),
    .served_o    (served_o),
    .dir_up_o    (dir_up_o),
    .door_open_o (door_open_o),
    .fault_o     (fault_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic observe(input logic [7:0] ev);
    logic [7:0] e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL event: got %02h expected none", ev);
    end else begin
      e = exp_q.pop_front();
      if (e !== ev) begin
        n_fail++;
        $display("FAIL event: got %02h expected %02h", ev, e);
      end
    end
  endtask

  // Monitor: samples at the falling edge, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_fault = 1'b0;
      end else begin
        if ({x1, x0} != 2'b00) observe({6'b000100, x1, x0});
        if (served_o != 4'b0000) observe({4'h2, served_o});
        if (fault_o && !prev_fault) observe(8'h30);
        prev_fault = fault_o;
      end
    end
  end

  // Car model: the floor feedback changes two cycles after a move command.
  initial begin
    logic [1:0] mv;
    forever begin
      @(negedge clk);
      mv = {x1, x0};
      if (car_en && rst_n && (mv == 2'b11 || mv == 2'b01)) begin
        repeat (2) @(negedge clk);
        #1;
        if (car_en) floor_i = (mv == 2'b11) ? floor_i + 2'd1 : floor_i - 2'd1;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset(input logic [1:0] fl);
    @(negedge clk);
    #1;
    car_en = 1'b0;
    emergency = 1'b0;
    call_i = '0;
    rst_n = 1'b0;
    floor_i = fl;
    exp_q.delete();
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic wait_x(input logic [1:0] v, input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if ({x1, x0} == v) begin
        ok = 1'b1;
        break;
      end
    end
    check("wait_cmd", 32'(ok), 32'd1);
  endtask

  task automatic wait_door(input int budget, input int exp_len);
    bit seen;
    int n;
    seen = 1'b0;
    n = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (door_open_o) begin
        seen = 1'b1;
        break;
      end
    end
    if (seen) begin
      n = 1;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (!door_open_o) break;
        n++;
      end
    end
    check("door_len", n, exp_len);
  endtask

  task automatic drain(input int budget);
    int i;
    i = 0;
    while (exp_q.size() != 0 && i < budget) begin
      @(negedge clk);
      #1;
      i++;
    end
    check("drain", exp_q.size(), 0);
  endtask

  initial begin
    int bad;

    // Reset values.
    do_reset(2'd0);
    @(negedge clk);
    check("rst_x", {x1, x0}, 2'b00);
    check("rst_pending", pending_o, 4'b0000);
    check("rst_served", served_o, 4'b0000);
    check("rst_dir", dir_up_o, 1'b1);
    check("rst_door", door_open_o, 1'b0);
    check("rst_fault", fault_o, 1'b0);

    // Floor 0, pulse call at floor 3: three up moves, serve, dwell 4.
    #1;
    car_en = 1'b1;
    call_i = 4'b1000;
    exp_q.push_back(8'h13);
    exp_q.push_back(8'h13);
    exp_q.push_back(8'h13);
    exp_q.push_back(8'h28);
    @(negedge clk);
    check("lat_pending", pending_o, 4'b1000);
    check("lat_x_early", {x1, x0}, 2'b00);
    #1 call_i = '0;
    @(negedge clk);
    check("lat_x_move", {x1, x0}, 2'b11);
    wait_door(60, 4);
    check("top_dir_flip", dir_up_o, 1'b0);
    check("top_pending", pending_o, 4'b0000);
    drain(5);

    // Floor 1, calls 3 and 0 while sweeping up: serve 3 first, then 0.
    do_reset(2'd1);
    car_en = 1'b1;
    call_i = 4'b1001;
    exp_q.push_back(8'h13);
    exp_q.push_back(8'h13);
    exp_q.push_back(8'h28);
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h21);
    @(negedge clk);
    #1 call_i = '0;
    drain(150);

    // Reset while an up command is on the outputs.
    do_reset(2'd0);
    exp_q.push_back(8'h13);
    call_i = 4'b0100;
    @(negedge clk);
    #1 call_i = '0;
    wait_x(2'b11, 10);
    #1 rst_n = 1'b0;
    #1;
    check("midmove_x", {x1, x0}, 2'b00);
    check("midmove_pending", pending_o, 4'b0000);
    check("midmove_dir", dir_up_o, 1'b1);

    // Floor feedback never changes: fault after 8 waiting cycles, then halt.
    do_reset(2'd0);
    exp_q.push_back(8'h13);
    exp_q.push_back(8'h30);
    call_i = 4'b0010;
    @(negedge clk);
    #1 call_i = '0;
    wait_x(2'b11, 10);
    repeat (8) @(negedge clk);
    check("fault_early", fault_o, 1'b0);
    @(negedge clk);
    check("fault_set", fault_o, 1'b1);
    #1;
    call_i = 4'b1000;
    floor_i = 2'd1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1 call_i = '0;
      if ({x1, x0} != 2'b00) bad++;
    end
    check("halt_hold", bad, 0);
    check("fault_sticky", fault_o, 1'b1);
    drain(2);

`ifndef FIRE_RECALL_EN
    // Emergency: masks a live command, freezes the FSM, calls still latch.
    do_reset(2'd0);
    exp_q.push_back(8'h13);
    call_i = 4'b0100;
    @(negedge clk);
    #1 call_i = '0;
    wait_x(2'b11, 10);
    #1 emergency = 1'b1;
    #1 check("emerg_mask", {x1, x0}, 2'b00);
    @(negedge clk);
    #1 call_i = 4'b0001;
    @(negedge clk);
    #1 call_i = '0;
    @(negedge clk);
    check("emerg_latch", pending_o, 4'b0101);
    #1 emergency = 1'b0;
    @(negedge clk);
    #1;
    emergency = 1'b1;
    floor_i = 2'd1;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if ({x1, x0} != 2'b00 || door_open_o) bad++;
    end
    check("emerg_frozen", bad, 0);
    // Calls above and below at floor 1: keep sweeping up.
    exp_q.push_back(8'h13);
    #1 emergency = 1'b0;
    drain(10);
    check("emerg_resume_pending", pending_o, 4'b0101);
    check("emerg_resume_dir", dir_up_o, 1'b1);
`endif

    // Call at the current floor: served next cycle, no move.
    do_reset(2'd2);
    call_i = 4'b0100;
    @(negedge clk);
    check("here_served_early", served_o, 4'b0000);
    check("here_pending", pending_o, 4'b0100);
    exp_q.push_back(8'h24);
    #1 call_i = '0;
    @(negedge clk);
    check("here_door", door_open_o, 1'b1);
    check("here_cleared", pending_o, 4'b0000);
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if ({x1, x0} != 2'b00) bad++;
    end
    check("here_no_move", bad, 0);
    check("here_door_closed", door_open_o, 1'b0);
    drain(2);

`ifdef FIRE_RECALL_EN
    // Fire recall from floor 2: calls flushed, two down moves, dwell at 0.
    do_reset(2'd2);
    car_en = 1'b1;
    emergency = 1'b1;
    call_i = 4'b1000;
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h11);
    @(negedge clk);
    #1 call_i = '0;
    wait_door(60, 4);
    check("recall_floor", floor_i, 2'd0);
    check("recall_pending", pending_o, 4'b0000);
    check("recall_dir", dir_up_o, 1'b0);
    drain(2);
    #1 emergency = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
